if_id_queue: RTL

Parametrised IF→ID decoupling queue for the MIPS32 pipeline. Buffers fetched (pc, inst) pairs from the AXI fetch side in a DEPTH-entry FIFO. Presents one instruction per unstalled cycle to ID, with a same-cycle bypass when empty. Throttles fetch through `next_pc_valid` and tags the branch delay-slot instruction.

---
 rtl/if_id_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: DEPTH-entry circular buffer with same-cycle bypass when empty and fetch throttling.
// Optional delay-slot tagging is compiled in with the IF_ID_DELAY_SLOT_EN macro.
module if_id_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [DATA_W-1:0] if_inst,
    input  logic              id_stall,
    input  logic              id_next_in_delay_slot,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic              id_in_delay_slot,
    output logic              next_pc_valid,
    output logic [CW-1:0]     count,
    output logic              overflow
);

    logic [ADDR_W+DATA_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          npv_q, npv_d;
    logic          overflow_q;

    logic empty, full;
    logic push, pop, bypass, wr_en, rd_en, ovf_set;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Flush and reset both kill the incoming fetch and any issue this cycle.
    assign push    = if_valid & ~flush & ~rst;
    assign pop     = ~id_stall & (~empty | push) & ~flush & ~rst;
    assign bypass  = empty & push & pop;
    assign rd_en   = pop & ~empty;
    assign wr_en   = push & ~bypass & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (rst || flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // One slot stays reserved for the fetch that may already be in flight.
    assign npv_d = ~rst & (count_d <= CW'(DEPTH - 2));

    always_ff @(posedge clk) begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        npv_q    <= npv_d;
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {if_pc, if_inst};
        end
    end

    always_comb begin
        id_valid = pop;
        id_pc    = '0;
        id_inst  = '0;
        if (pop) begin
            if (empty) begin
                id_pc   = if_pc;
                id_inst = if_inst;
            end else begin
                {id_pc, id_inst} = mem_q[rd_ptr_q];
            end
        end
    end

`ifdef IF_ID_DELAY_SLOT_EN
    logic pend_q, pend_d;

    // A pulse that arrives while nothing issues is held until the next issue.
    always_comb begin
        pend_d = pend_q;
        if (rst || flush) begin
            pend_d = 1'b0;
        end else if (id_next_in_delay_slot) begin
            pend_d = 1'b1;
        end else if (pop) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign id_in_delay_slot = pend_q & pop;
`else
    logic unused_ds;
    assign unused_ds        = id_next_in_delay_slot;
    assign id_in_delay_slot = 1'b0;
`endif

    assign next_pc_valid = npv_q;
    assign count         = count_q;
    assign overflow      = overflow_q;

endmodule
